// File: rtl/ta_adc_capture_if.sv
// ta_adc_capture_if: bundles the two streaming paths of the ADC capture block.
//   merge_data / mereg_datv : merged ADC words from the merge stage. There is no backpressure.
//   cap_data / cap_valid / cap_ready / cap_last : the frame readout stream.
// Modports:
//   slave  - the capture block. It sinks merged words and sources the readout stream.
//   master - the environment. It sources merged words and sinks the readout stream.
interface ta_adc_capture_if #(
  parameter int W = 56
);
  logic [W-1:0] merge_data;
  logic         mereg_datv;
  logic [W-1:0] cap_data;
  logic         cap_valid;
  logic         cap_ready;
  logic         cap_last;

  modport slave (
    input  merge_data,
    input  mereg_datv,
    input  cap_ready,
    output cap_data,
    output cap_valid,
    output cap_last
  );

  modport master (
    output merge_data,
    output mereg_datv,
    output cap_ready,
    input  cap_data,
    input  cap_valid,
    input  cap_last
  );
endinterface

// File: rtl/ta_adc_capture.sv
// ta_adc_capture: pre/post-trigger capture of merged ADC words into a circular RAM,
// followed by a full-frame readout over a valid/ready stream.
// Ports:
//   clk62      - the only clock. All logic runs on its rising edge.
//   rst        - synchronous reset, active low.
//   bus        - merged-word input and readout stream (see ta_adc_capture_if).
//   arm        - single-cycle pulse. Starts a capture when the block is idle.
//   sw_trig    - forced trigger pulse. Only honoured while armed.
//   trig_level - signed threshold for the edge trigger.
//   trig_edge  - edge select: 0 = rising, 1 = falling.
//   busy       - high in every state except idle.
//   trig_pos   - sample index of the trigger inside the trigger word. Held until the next arm.
module ta_adc_capture #(
  parameter int ADC0_0   = 14,
  parameter int ADC0_1   = 56,
  parameter int PRE_LEN  = 16,
  parameter int POST_LEN = 48
) (
  input  logic                     clk62,
  input  logic                     rst,
  ta_adc_capture_if.slave          bus,
  input  logic                     arm,
  input  logic                     sw_trig,
  input  logic signed [ADC0_0-1:0] trig_level,
  input  logic                     trig_edge,
  output logic                     busy,
  output logic [1:0]               trig_pos
);

  localparam int DEPTH = PRE_LEN + POST_LEN;
  localparam int AW    = $clog2(DEPTH);
  localparam int NS    = ADC0_1 / ADC0_0;

  localparam logic [AW:0] PRE_LAST  = (AW+1)'(PRE_LEN - 1);
  localparam logic [AW:0] POST_LAST = (AW+1)'(POST_LEN - 1);
  localparam logic [AW:0] DEPTH_CNT = (AW+1)'(DEPTH);
  localparam logic [AW:0] CNT_ONE   = (AW+1)'(1);

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_PRE_FILL = 3'd1;
  localparam logic [2:0] ST_ARMED    = 3'd2;
  localparam logic [2:0] ST_POST     = 3'd3;
  localparam logic [2:0] ST_READOUT  = 3'd4;

  // Edge detect between a sample and its predecessor. The compare is signed.
  function automatic logic edge_hit(input logic signed [ADC0_0-1:0] pred,
                                    input logic signed [ADC0_0-1:0] cur,
                                    input logic signed [ADC0_0-1:0] lvl,
                                    input logic                     falling);
    if (falling) edge_hit = (pred > lvl) && (cur <= lvl);
    else         edge_hit = (pred < lvl) && (cur >= lvl);
  endfunction

  logic [ADC0_1-1:0] mem [DEPTH];

  logic [2:0]               state_q,     state_d;
  logic [AW-1:0]            wptr_q,      wptr_d;
  logic [AW:0]              cnt_q,       cnt_d;
  logic signed [ADC0_0-1:0] prev_q,      prev_d;
  logic [AW-1:0]            taddr_q,     taddr_d;
  logic [AW-1:0]            raddr_q,     raddr_d;
  logic [AW:0]              rd_cnt_q,    rd_cnt_d;
  logic [1:0]               trig_pos_q,  trig_pos_d;
  logic                     sw_pend_q,   sw_pend_d;
  logic [ADC0_1-1:0]        cap_data_q,  cap_data_d;
  logic                     cap_valid_q, cap_valid_d;
  logic                     cap_last_q,  cap_last_d;

  logic signed [ADC0_0-1:0] samp [NS];
  logic signed [ADC0_0-1:0] pred [NS];
  logic [NS-1:0]            hits;
  logic                     hit_any;
  logic [1:0]               hit_idx;
  logic                     capturing;
  logic                     mem_we;

  // Split the merged word into samples. The predecessor of s0 is the newest
  // sample of the previous valid word.
  always_comb begin
    hit_idx = '0;
    for (int i = 0; i < NS; i++) begin
      samp[i] = $signed(bus.merge_data[i*ADC0_0 +: ADC0_0]);
    end
    pred[0] = prev_q;
    for (int i = 1; i < NS; i++) begin
      pred[i] = samp[i-1];
    end
    for (int i = 0; i < NS; i++) begin
      hits[i] = edge_hit(pred[i], samp[i], trig_level, trig_edge);
    end
    // Scan from high to low so that the lowest hit index is the one kept.
    for (int i = NS - 1; i >= 0; i--) begin
      if (hits[i]) hit_idx = 2'(i);
    end
    hit_any = |hits;
  end

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    cnt_d       = cnt_q;
    prev_d      = prev_q;
    taddr_d     = taddr_q;
    raddr_d     = raddr_q;
    rd_cnt_d    = rd_cnt_q;
    trig_pos_d  = trig_pos_q;
    sw_pend_d   = sw_pend_q;
    cap_data_d  = cap_data_q;
    cap_valid_d = cap_valid_q;
    cap_last_d  = cap_last_q;
    mem_we      = 1'b0;

    capturing = (state_q == ST_PRE_FILL) || (state_q == ST_ARMED) || (state_q == ST_POST);

    // Every valid word seen while capturing goes into the ring and refreshes the history.
    if (capturing && bus.mereg_datv) begin
      mem_we = 1'b1;
      wptr_d = wptr_q + 1'b1;
      prev_d = samp[NS-1];
    end

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          state_d    = ST_PRE_FILL;
          wptr_d     = '0;
          cnt_d      = '0;
          trig_pos_d = '0;
          sw_pend_d  = 1'b0;
        end
      end

      ST_PRE_FILL: begin
        if (bus.mereg_datv) begin
          if (cnt_q == PRE_LAST) begin
            state_d = ST_ARMED;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      ST_ARMED: begin
        // A software trigger that arrives without data waits for the next valid word.
        if (bus.mereg_datv && (hit_any || sw_trig || sw_pend_q)) begin
          trig_pos_d = hit_any ? hit_idx : 2'd0;
          taddr_d    = wptr_q;
          sw_pend_d  = 1'b0;
          cnt_d      = CNT_ONE;
          state_d    = ST_POST;
        end else if (sw_trig) begin
          sw_pend_d = 1'b1;
        end
      end

      ST_POST: begin
        if (bus.mereg_datv) begin
          if (cnt_q == POST_LAST) begin
            state_d  = ST_READOUT;
            raddr_d  = taddr_q - AW'(PRE_LEN);
            rd_cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
      end

      ST_READOUT: begin
        if (cap_valid_q && bus.cap_ready) begin
          cap_valid_d = 1'b0;
          if (cap_last_q) begin
            cap_last_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
        // The output register doubles as the RAM read register. A new read is
        // issued only when that register is empty or is being drained this cycle,
        // so a stalled word holds and is never overwritten.
        if ((rd_cnt_q != DEPTH_CNT) && (!cap_valid_q || bus.cap_ready)) begin
          cap_data_d  = mem[raddr_q];
          cap_valid_d = 1'b1;
          cap_last_d  = (rd_cnt_q == DEPTH_CNT - CNT_ONE);
          raddr_d     = raddr_q + 1'b1;
          rd_cnt_d    = rd_cnt_q + CNT_ONE;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Control and readout registers
  always_ff @(posedge clk62) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      wptr_q      <= '0;
      cnt_q       <= '0;
      prev_q      <= '0;
      taddr_q     <= '0;
      raddr_q     <= '0;
      rd_cnt_q    <= '0;
      trig_pos_q  <= '0;
      sw_pend_q   <= 1'b0;
      cap_data_q  <= '0;
      cap_valid_q <= 1'b0;
      cap_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      cnt_q       <= cnt_d;
      prev_q      <= prev_d;
      taddr_q     <= taddr_d;
      raddr_q     <= raddr_d;
      rd_cnt_q    <= rd_cnt_d;
      trig_pos_q  <= trig_pos_d;
      sw_pend_q   <= sw_pend_d;
      cap_data_q  <= cap_data_d;
      cap_valid_q <= cap_valid_d;
      cap_last_q  <= cap_last_d;
    end
  end

  // Capture RAM. Reset does not clear its contents.
  always_ff @(posedge clk62) begin
    if (mem_we) mem[wptr_q] <= bus.merge_data;
  end

  assign bus.cap_data  = cap_data_q;
  assign bus.cap_valid = cap_valid_q;
  assign bus.cap_last  = cap_last_q;
  assign busy          = (state_q != ST_IDLE);
  assign trig_pos      = trig_pos_q;

endmodule

// File: doc/ta_adc_capture.md
TA_ADC_CAPTURE -- requirements
Module: ta_adc_capture

Interface
REQ-001 Parameter ADC0_0, default 14: bits per ADC sample, two's complement.
REQ-002 Parameter ADC0_1, default 56: merged word width, four samples, s0 = bits 13:0 (oldest) to s3 = bits 55:42 (newest).
REQ-003 Parameter PRE_LEN, default 16: pre-trigger words retained.
REQ-004 Parameter POST_LEN, default 48: words from the trigger word onward; PRE_LEN+POST_LEN SHALL be a power of two, DEPTH = 64, AW = 6.
REQ-005 clk62  in  1  sole clock; all logic on its rising edge.
REQ-006 rst  in  1  synchronous, active-low reset.
REQ-007 merge_data  in  56  merged ADC word from the merge stage.
REQ-008 mereg_datv  in  1  merge_data valid for this cycle, no backpressure.
REQ-009 arm  in  1  single-cycle pulse starting a capture.
REQ-010 sw_trig  in  1  forced trigger pulse.
REQ-011 trig_level  in  14  signed threshold.
REQ-012 trig_edge  in  1  0 = rising, 1 = falling.
REQ-013 cap_data  out  56  readout word.
REQ-014 cap_valid  out  1  cap_data valid.
REQ-015 cap_ready  in  1  consumer accepts; transfer when cap_valid and cap_ready.
REQ-016 cap_last  out  1  marks word DEPTH-1 of the frame.
REQ-017 busy  out  1  high in every state except IDLE.
REQ-018 trig_pos  out  2  sample index within the trigger word; held until the next arm.

Function
REQ-019 FSM states SHALL be IDLE, PRE_FILL, ARMED, POST, READOUT.
REQ-020 IDLE: arm=1 -> PRE_FILL, write pointer and counters cleared; arm ignored in all other states.
REQ-021 PRE_FILL/ARMED/POST: each mereg_datv word SHALL be written to the DEPTH-word circular RAM at wptr, wptr+1 mod DEPTH.
REQ-022 PRE_FILL -> ARMED after PRE_LEN valid words; trigger conditions in PRE_FILL ignored.
REQ-023 Sample history: register prev = s3 of last valid word, updated on every valid word outside READOUT and IDLE.
REQ-024 Rising hit at si: predecessor < trig_level and si >= trig_level (predecessor of s0 = prev, of si = s(i-1)); falling: predecessor > level and si <= level; signed compare.
REQ-025 ARMED: on a valid word with any hit, trig_pos = lowest hit index, word written, taddr = its address, -> POST.
REQ-026 sw_trig=1 in ARMED: trigger on the next valid word (or same cycle if mereg_datv=1), trig_pos=0; sw_trig elsewhere ignored; edge hit takes priority for trig_pos when both.
REQ-027 Trigger word counts as post word 1; POST -> READOUT after POST_LEN-1 further valid words.
REQ-028 READOUT: input ignored; read DEPTH words starting at taddr-PRE_LEN mod DEPTH, wrapping; trigger word appears as output index PRE_LEN.
REQ-029 RAM read synchronous, one-cycle latency; first cap_valid no later than 2 cycles after entering READOUT.
REQ-030 While cap_valid=1 and cap_ready=0, cap_data and cap_last SHALL hold stable; no word dropped or duplicated.
REQ-031 With cap_ready held high, one word per cycle SHALL transfer after the first.
REQ-032 Transfer of cap_last word -> IDLE next cycle, cap_valid=0.
REQ-033 Arm and trigger on same cycle: arm accepted, trigger ignored.

Reset
REQ-034 rst=0 sampled at a clock edge: state IDLE, pointers/counters 0, prev 0, cap_data 0, cap_valid 0, cap_last 0, busy 0, trig_pos 0; RAM content not cleared.
REQ-035 Reset mid-capture or mid-readout SHALL abort immediately; outputs take reset values next cycle; no partial frame resumes.

Verification
REQ-036 Ramp input (sample value = global sample index), level 1000 rising, arm at t0 -> 64-word frame, word 16 contains sample 1000 at trig_pos=(1000 mod 4)=0, words contiguous across RAM wrap.
REQ-037 Crossing at s2 (s1=-5, s2=+5, level 0 rising) -> trig_pos=2; same data with trig_edge=1 -> no trigger, busy stays 1.
REQ-038 Crossing across word boundary (prev s3=-1, s0=+1, level 0) -> trig_pos=0.
REQ-039 Trigger-condition data during PRE_FILL then flat data, then sw_trig -> trigger only from sw_trig, trig_pos=0.
REQ-040 Random cap_ready (50% duty) during readout -> exactly 64 transfers, data stable while stalled, cap_last only on 64th.
REQ-041 rst=0 for one cycle mid-POST and mid-READOUT -> cap_valid=0, busy=0 next cycle; new arm yields a correct full frame.
